// File: rtl/rx_iq_pkg.sv
// Shared definitions for the receive I/Q packing path: FSM states, frame markers
// and the word-packing function that the SMI-side model also uses.
package rx_iq_pkg;

  localparam int DEFAULT_SAMPLE_W = 13;

  localparam logic [1:0] SYNC_I = 2'b10;
  localparam logic [1:0] SYNC_Q = 2'b01;

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    STREAM
  } state_t;

  // Every word carries its own markers, so the Pi can realign after any drop
  function automatic logic [31:0] pack_iq(input logic [DEFAULT_SAMPLE_W-1:0] i_val,
                                          input logic [DEFAULT_SAMPLE_W-1:0] q_val);
    return {SYNC_I, i_val, 1'b0, SYNC_Q, q_val, 1'b0};
  endfunction

endpackage

// File: rtl/iq_skid_buffer.sv
// Two-entry skid buffer (output register plus one holding register) with
// valid/ready handshakes on both sides and a synchronous flush.
module iq_skid_buffer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic              hold_valid;
  logic [DATA_W-1:0] hold_data;
  logic              pop;
  logic              accept;

  assign pop      = out_valid & out_ready;
  // The holding register is only ever occupied while the output register is
  assign in_ready = ~hold_valid | pop;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (pop) begin
      if (hold_valid) begin
        out_data <= hold_data;
        if (accept) begin
          hold_data <= in_data;
        end else begin
          hold_valid <= 1'b0;
        end
      end else if (accept) begin
        out_data <= in_data;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_data  <= in_data;
      end else begin
        hold_valid <= 1'b1;
        hold_data  <= in_data;
      end
    end
  end

endmodule

// File: rtl/rx_iq_packer.sv
// Receive I/Q packer: channel select, 32-bit framing, skid buffering into the SMI
// read FIFO and overflow statistics. RX_IQ_PACKER_DROP_CNT_EN enables the drop counter.
module rx_iq_packer
  import rx_iq_pkg::*;
#(
  parameter int SAMPLE_W   = DEFAULT_SAMPLE_W,
  parameter int DROP_CNT_W = 16
) (
  input  logic                  i_sys_clk,
  input  logic                  i_reset,
  input  logic                  i_enable,
  input  logic                  i_channel,
  input  logic                  i_rx_valid_09,
  input  logic [SAMPLE_W-1:0]   i_rx_i_09,
  input  logic [SAMPLE_W-1:0]   i_rx_q_09,
  input  logic                  i_rx_valid_24,
  input  logic [SAMPLE_W-1:0]   i_rx_i_24,
  input  logic [SAMPLE_W-1:0]   i_rx_q_24,
  output logic                  o_fifo_push,
  output logic [31:0]           o_fifo_pushed_data,
  input  logic                  i_fifo_full,
  input  logic                  i_clear_stats,
  output logic                  o_overflow,
  output logic [DROP_CNT_W-1:0] o_drop_cnt,
  output logic                  o_active
);

  state_t              state;
  state_t              state_next;
  logic                chan_reg;
  logic                chan_change;
  logic                sel_valid;
  logic [SAMPLE_W-1:0] sel_i;
  logic [SAMPLE_W-1:0] sel_q;
  logic [31:0]         sel_word;
  logic                flush;
  logic                enq_valid;
  logic                enq_ready;
  logic                buf_out_ready;
  logic                buf_out_valid;
  logic                drop;
  logic                overflow;

  assign sel_valid   = i_channel ? i_rx_valid_24 : i_rx_valid_09;
  assign sel_i       = i_channel ? i_rx_i_24 : i_rx_i_09;
  assign sel_q       = i_channel ? i_rx_q_24 : i_rx_q_09;
  assign sel_word    = pack_iq(sel_i, sel_q);
  assign chan_change = (state == STREAM) && (i_channel != chan_reg);

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      state    <= IDLE;
      chan_reg <= 1'b0;
    end else begin
      state    <= state_next;
      chan_reg <= i_channel;
    end
  end

  // Losing enable or switching channel throws away buffered words rather than draining them
  always_comb begin
    state_next = state;
    flush      = 1'b0;
    enq_valid  = 1'b0;
    if (!i_enable) begin
      state_next = IDLE;
      flush      = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          flush      = 1'b1;
          state_next = SYNC;
        end
        SYNC: begin
          if (sel_valid) begin
            enq_valid  = 1'b1;
            state_next = STREAM;
          end
        end
        STREAM: begin
          if (chan_change) begin
            flush      = 1'b1;
            state_next = SYNC;
          end else begin
            enq_valid = sel_valid;
          end
        end
        default: begin
          flush      = 1'b1;
          state_next = IDLE;
        end
      endcase
    end
  end

  assign buf_out_ready = ~i_fifo_full & (state == STREAM);
  assign o_fifo_push   = buf_out_valid & buf_out_ready;
  assign o_active      = (state == STREAM);
  assign drop          = enq_valid & ~enq_ready;

  iq_skid_buffer #(
    .DATA_W(32)
  ) u_skid (
    .clk      (i_sys_clk),
    .reset    (i_reset),
    .flush    (flush),
    .in_valid (enq_valid),
    .in_data  (sel_word),
    .in_ready (enq_ready),
    .out_ready(buf_out_ready),
    .out_valid(buf_out_valid),
    .out_data (o_fifo_pushed_data)
  );

  // A drop in the same cycle as a clear survives the clear
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (i_clear_stats) begin
      overflow <= 1'b0;
    end
  end

  assign o_overflow = overflow;

`ifdef RX_IQ_PACKER_DROP_CNT_EN
  logic [DROP_CNT_W-1:0] drop_cnt;

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      drop_cnt <= '0;
    end else if (i_clear_stats) begin
      drop_cnt <= {{(DROP_CNT_W-1){1'b0}}, drop};
    end else if (drop && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + 1'b1;
    end
  end

  assign o_drop_cnt = drop_cnt;
`else
  assign o_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_rx_iq_packer.sv
// Self-checking bench for rx_iq_packer: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the packer.
module tb_rx_iq_packer;

  localparam int SW = 13;
  localparam int CW = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          i_sys_clk = 1'b0;
  logic          i_reset = 1'b1;
  logic          i_enable = 1'b0;
  logic          i_channel = 1'b0;
  logic          i_rx_valid_09 = 1'b0;
  logic [SW-1:0] i_rx_i_09 = '0;
  logic [SW-1:0] i_rx_q_09 = '0;
  logic          i_rx_valid_24 = 1'b0;
  logic [SW-1:0] i_rx_i_24 = '0;
  logic [SW-1:0] i_rx_q_24 = '0;
  logic          i_fifo_full = 1'b0;
  logic          i_clear_stats = 1'b0;
  logic          o_fifo_push;
  logic [31:0]   o_fifo_pushed_data;
  logic          o_overflow;
  logic [CW-1:0] o_drop_cnt;
  logic          o_active;

  always #5 i_sys_clk = ~i_sys_clk;

  rx_iq_packer #(
    .SAMPLE_W(SW),
    .DROP_CNT_W(CW)
  ) dut (
    .i_sys_clk         (i_sys_clk),
    .i_reset           (i_reset),
    .i_enable          (i_enable),
    .i_channel         (i_channel),
    .i_rx_valid_09     (i_rx_valid_09),
    .i_rx_i_09         (i_rx_i_09),
    .i_rx_q_09         (i_rx_q_09),
    .i_rx_valid_24     (i_rx_valid_24),
    .i_rx_i_24         (i_rx_i_24),
    .i_rx_q_24         (i_rx_q_24),
    .o_fifo_push       (o_fifo_push),
    .o_fifo_pushed_data(o_fifo_pushed_data),
    .i_fifo_full       (i_fifo_full),
    .i_clear_stats     (i_clear_stats),
    .o_overflow        (o_overflow),
    .o_drop_cnt        (o_drop_cnt),
    .o_active          (o_active)
  );

  int testsRun = 0;
  int testsFailed = 0;
  int dutPushes = 0;

  // Reference model: queue of buffered words (capacity 2) and a few flags
  logic [31:0] modelQ[$];
  bit          armed = 0;
  bit          locked = 0;
  bit          prevChannel = 0;
  bit          modelOverflow = 0;
  int          modelDrops = 0;

  function automatic logic [31:0] packWord(input logic [SW-1:0] iv, input logic [SW-1:0] qv);
    return 32'h8000_4000 | (32'(iv) << 17) | (32'(qv) << 1);
  endfunction

  function automatic int expCount(input int n);
`ifdef RX_IQ_PACKER_DROP_CNT_EN
    return n;
`else
    return 0 * n;
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelUpdate();
    bit          selValid;
    logic [31:0] word;
    bit          dropNow;
    selValid = i_channel ? i_rx_valid_24 : i_rx_valid_09;
    word     = i_channel ? packWord(i_rx_i_24, i_rx_q_24) : packWord(i_rx_i_09, i_rx_q_09);
    dropNow  = 0;
    if (i_reset) begin
      modelQ.delete();
      armed = 0;
      locked = 0;
      modelOverflow = 0;
      modelDrops = 0;
      prevChannel = 0;
    end else begin
      if (!i_enable) begin
        modelQ.delete();
        armed = 0;
        locked = 0;
      end else if (!armed) begin
        armed = 1;
      end else if (locked && (i_channel != prevChannel)) begin
        modelQ.delete();
        locked = 0;
      end else begin
        if (locked && modelQ.size() > 0 && !i_fifo_full) void'(modelQ.pop_front());
        if (selValid) begin
          if (modelQ.size() < 2) begin
            modelQ.push_back(word);
            locked = 1;
          end else begin
            dropNow = 1;
          end
        end
      end
      if (i_clear_stats) begin
        modelOverflow = dropNow;
        modelDrops = dropNow ? 1 : 0;
      end else if (dropNow) begin
        modelOverflow = 1;
        if (modelDrops < CNT_MAX) modelDrops++;
      end
      prevChannel = i_channel;
    end
  endtask

  // One clock: compare outputs against the model mid-cycle, then advance both
  task automatic stepCycle();
    bit expPush;
    #2;
    expPush = locked && (modelQ.size() > 0) && !i_fifo_full;
    checkOutput("push", {31'b0, o_fifo_push}, {31'b0, expPush});
    if (expPush) checkOutput("data", o_fifo_pushed_data, modelQ[0]);
    checkOutput("active", {31'b0, o_active}, {31'b0, locked});
    checkOutput("overflow", {31'b0, o_overflow}, {31'b0, modelOverflow});
    checkOutput("drop_cnt", {16'b0, o_drop_cnt}, 32'(expCount(modelDrops)));
    if (o_fifo_push === 1'b1) dutPushes++;
    @(posedge i_sys_clk);
    modelUpdate();
    #1;
  endtask

  task automatic applyStimulus(input bit v09, input bit v24);
    i_rx_valid_09 = v09;
    i_rx_valid_24 = v24;
    i_rx_i_09 = SW'($urandom_range(0, 8191));
    i_rx_q_09 = SW'($urandom_range(0, 8191));
    i_rx_i_24 = SW'($urandom_range(0, 8191));
    i_rx_q_24 = SW'($urandom_range(0, 8191));
    stepCycle();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_push"}, {31'b0, o_fifo_push}, 32'd0);
    checkOutput({tag, "_data"}, o_fifo_pushed_data, 32'd0);
    checkOutput({tag, "_ovf"}, {31'b0, o_overflow}, 32'd0);
    checkOutput({tag, "_cnt"}, {16'b0, o_drop_cnt}, 32'd0);
    checkOutput({tag, "_active"}, {31'b0, o_active}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge i_sys_clk);
    #1;
    checkResetState("reset");

    // Single sample on the 900 MHz channel
    i_reset = 1'b0;
    i_enable = 1'b1;
    i_channel = 1'b0;
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    i_rx_valid_09 = 1'b1;
    i_rx_i_09 = 13'h1ABC;
    i_rx_q_09 = 13'h0123;
    stepCycle();
    dutPushes = 0;
    i_rx_valid_09 = 1'b0;
    #2;
    checkOutput("first_word", o_fifo_pushed_data, packWord(13'h1ABC, 13'h0123));
    checkOutput("first_active", {31'b0, o_active}, 32'd1);
    stepCycle();
    repeat (3) applyStimulus(0, 0);
    checkOutput("first_push_count", dutPushes, 32'd1);

    // 100 samples at full rate on 2.4 GHz with 900 MHz noise strobes
    i_channel = 1'b1;
    applyStimulus(0, 0);
    dutPushes = 0;
    for (int n = 0; n < 100; n++) applyStimulus(1'($urandom_range(0, 1)), 1);
    repeat (3) applyStimulus(1, 0);
    checkOutput("stream_push_count", dutPushes, 32'd100);
    checkOutput("stream_no_drop", {16'b0, o_drop_cnt}, 32'd0);

    // FIFO full for three cycles at full rate
    i_clear_stats = 1'b1;
    applyStimulus(0, 1);
    i_clear_stats = 1'b0;
    repeat (4) applyStimulus(0, 1);
    i_fifo_full = 1'b1;
    repeat (3) applyStimulus(0, 1);
    i_fifo_full = 1'b0;
    repeat (4) applyStimulus(0, 1);
    repeat (3) applyStimulus(0, 0);
    checkOutput("full3_ovf", {31'b0, o_overflow}, 32'd1);
    checkOutput("full3_cnt", {16'b0, o_drop_cnt}, 32'(expCount(2)));

    // Clear coinciding with a drop after five prior drops
    i_clear_stats = 1'b1;
    applyStimulus(0, 0);
    i_clear_stats = 1'b0;
    i_fifo_full = 1'b1;
    repeat (7) applyStimulus(0, 1);
    checkOutput("five_drops", {16'b0, o_drop_cnt}, 32'(expCount(5)));
    i_clear_stats = 1'b1;
    applyStimulus(0, 1);
    i_clear_stats = 1'b0;
    checkOutput("clear_drop_cnt", {16'b0, o_drop_cnt}, 32'(expCount(1)));
    checkOutput("clear_drop_ovf", {31'b0, o_overflow}, 32'd1);

    // Channel switch with words pending under full
    i_channel = 1'b0;
    applyStimulus(0, 1);
    checkOutput("switch_active", {31'b0, o_active}, 32'd0);
    i_fifo_full = 1'b0;
    applyStimulus(0, 1);
    applyStimulus(1, 1);
    applyStimulus(0, 1);
    repeat (2) applyStimulus(0, 0);

    // Reset with disable while the buffer is full
    i_fifo_full = 1'b1;
    repeat (4) applyStimulus(1, 0);
    i_reset = 1'b1;
    i_enable = 1'b0;
    applyStimulus(1, 0);
    i_reset = 1'b0;
    i_fifo_full = 1'b0;
    #2;
    checkResetState("midreset");
    applyStimulus(0, 0);
    i_enable = 1'b1;

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      i_reset = ($urandom_range(0, 499) == 0);
      i_enable = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 49) == 0) i_channel = ~i_channel;
      i_fifo_full = ($urandom_range(0, 2) == 0);
      i_clear_stats = ($urandom_range(0, 29) == 0);
      applyStimulus(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 7));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
